// File: rtl/pipe_sched_pkg.sv
// ----------------------------------------------------------------------------
// pipe_sched_pkg
//   Shared types and constants for pipe_sched_arbiter and its round-robin
//   sub-module.
//   - state_e : issue/drain FSM states
//   - tag_t   : request tag carried alongside an operation through the
//               pipeline-latency delay line
//   - STAT_W  : width of each statistics counter (PIPE_SCHED_STATS_EN)
//   - sat_inc : saturating increment used by the statistics counters
// ----------------------------------------------------------------------------
package pipe_sched_pkg;

  // Statistics counter width.
  localparam int STAT_W = 16;

  // Tag id width sized for the largest supported requester count (8), so the
  // struct does not depend on the N_REQ parameter of the instantiating module.
  localparam int ID_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage : pipe_sched_pkg

// File: rtl/basic_pipeline.sv
// ----------------------------------------------------------------------------
// basic_pipeline
//   Three-stage arithmetic pipeline computing F = (A + B + C - D) * D modulo
//   2^W. No stall. F reflects a given A..D set three clock edges after that
//   set is presented.
// Ports
//   clk      : clock, all logic on posedge
//   rst      : synchronous active-high reset
//   a,b,c,d  : operands
//   f        : result
// ----------------------------------------------------------------------------
module basic_pipeline #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  output logic [W-1:0] f
);

  logic [W-1:0] s1_sum_q, s1_sum_d;
  logic [W-1:0] s1_d_q, s1_d_d;
  logic [W-1:0] s2_prod_q, s2_prod_d;
  logic [W-1:0] f_q, f_d;

  always_comb begin
    s1_sum_d  = a + b + c - d;
    s1_d_d    = d;
    s2_prod_d = s1_sum_q * s1_d_q;
    f_d       = s2_prod_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_sum_q  <= '0;
      s1_d_q    <= '0;
      s2_prod_q <= '0;
      f_q       <= '0;
    end else begin
      s1_sum_q  <= s1_sum_d;
      s1_d_q    <= s1_d_d;
      s2_prod_q <= s2_prod_d;
      f_q       <= f_d;
    end
  end

  assign f = f_q;

endmodule : basic_pipeline

// File: rtl/pipe_sched_arbiter_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin selector. The search for a set request
//   bit starts at index ptr and wraps; the first hit wins.
// Ports
//   req       : request vector (already qualified by the caller)
//   ptr       : search start index, must be < N_REQ
//   grant     : one-hot grant, zero when no request is set
//   grant_idx : index of the granted requester (0 when none)
//   grant_vld : any grant this cycle
// ----------------------------------------------------------------------------
module rr_arbiter
  import pipe_sched_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             grant_vld
);

  // NOTE: every output gets a default before any conditional assignment so
  // no path leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    // Scan from the farthest offset down to offset 0: the last hit written is
    // the one closest to ptr, which is the round-robin winner.
    for (int off = N_REQ - 1; off >= 0; off--) begin
      if (req[(int'(ptr) + off) % N_REQ]) begin
        grant_vld = 1'b1;
        grant_idx = ID_W'((int'(ptr) + off) % N_REQ);
      end
    end
    grant = '0;
    for (int i = 0; i < N_REQ; i++) begin
      grant[i] = grant_vld && (grant_idx == ID_W'(i));
    end
  end

endmodule : rr_arbiter

// File: rtl/pipe_sched_arbiter.sv
// ----------------------------------------------------------------------------
// pipe_sched_arbiter
//   Shares one basic_pipeline between N_REQ requesters. A round-robin arbiter
//   picks one operand set per cycle and registers it onto pipe_a..pipe_d. A
//   requester tag follows each operation through a delay line matched to the
//   pipeline latency, so each result is returned to the requester that issued
//   it. An enable/drain FSM stops issue and reports when nothing is in flight.
//
// Ports
//   clk, rst         : clock; synchronous active-high reset
//   en               : 1 = issue allowed, 0 = stop issue and drain
//   req_valid        : per-requester operand set valid
//   req_ready        : one-hot grant (combinational); handshake = valid&ready
//   req_a..req_d     : packed operands, requester i at [i*DW +: DW]
//   pipe_a..pipe_d   : registered operands to basic_pipeline
//   pipe_f           : basic_pipeline result
//   rsp_valid        : one-hot single-cycle pulse per completed operation
//   rsp_data         : result for the requester flagged in rsp_valid
//   idle             : FSM idle and no operation in flight
//   stat_grant_cnt   : (PIPE_SCHED_STATS_EN) 16-bit saturating grant count per
//                      requester, requester i at [i*16 +: 16]
//   stat_busy_cnt    : (PIPE_SCHED_STATS_EN) saturating count of cycles with an
//                      operation in the tag delay line
//
// Configuration macro: PIPE_SCHED_STATS_EN enables the statistics counters and
// their output ports.
//
// Timing: handshake cycle ends at edge E, operands appear on pipe_a..d after
// E; pipe_f matches them after E+PIPE_LAT; rsp_data captures pipe_f at edge
// E+PIPE_LAT+1. The tag therefore sits in an issue register (aligned with
// pipe_a..d) followed by PIPE_LAT line stages.
// ----------------------------------------------------------------------------
module pipe_sched_arbiter
  import pipe_sched_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int DW       = 10,
  parameter int PIPE_LAT = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*DW-1:0] req_a,
  input  logic [N_REQ*DW-1:0] req_b,
  input  logic [N_REQ*DW-1:0] req_c,
  input  logic [N_REQ*DW-1:0] req_d,
  output logic [DW-1:0]       pipe_a,
  output logic [DW-1:0]       pipe_b,
  output logic [DW-1:0]       pipe_c,
  output logic [DW-1:0]       pipe_d,
  input  logic [DW-1:0]       pipe_f,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]       rsp_data,
  output logic                idle
`ifdef PIPE_SCHED_STATS_EN
  ,
  output logic [N_REQ*STAT_W-1:0] stat_grant_cnt,
  output logic [STAT_W-1:0]       stat_busy_cnt
`endif
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic              idle_q, idle_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [DW-1:0]     pipe_a_q, pipe_a_d;
  logic [DW-1:0]     pipe_b_q, pipe_b_d;
  logic [DW-1:0]     pipe_c_q, pipe_c_d;
  logic [DW-1:0]     pipe_d_q, pipe_d_d;
  tag_t              tag_issue_q, tag_issue_d;
  tag_t              tag_line_q [PIPE_LAT];
  tag_t              tag_line_d [PIPE_LAT];
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]     rsp_data_q, rsp_data_d;

  logic              issue_en;
  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   grant_idx;
  logic              grant_vld;
  logic              line_busy;
  tag_t              out_tag;

  // --------------------------------------------------------------------------
  // Arbitration: only RUN with en high may grant.
  // --------------------------------------------------------------------------
  assign issue_en = (state_q == RUN) && en;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr (
    .req       (req_valid & {N_REQ{issue_en}}),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign req_ready = grant;

  // Anything still travelling toward the response register.
  always_comb begin
    line_busy = tag_issue_q.vld;
    for (int k = 0; k < PIPE_LAT; k++) begin
      line_busy = line_busy | tag_line_q[k].vld;
    end
  end

  assign out_tag = tag_line_q[PIPE_LAT-1];

  // --------------------------------------------------------------------------
  // FSM next state. A re-raised en during DRAIN is ignored until the line is
  // empty; IDLE then moves to RUN on the following edge.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en)         state_d = RUN;
      RUN:     if (!en)        state_d = DRAIN;
      DRAIN:   if (!line_busy) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
    idle_d = (state_d == IDLE);
  end

  // --------------------------------------------------------------------------
  // Issue, tag delay line and response capture.
  // --------------------------------------------------------------------------
  always_comb begin
    ptr_d       = ptr_q;
    pipe_a_d    = pipe_a_q;
    pipe_b_d    = pipe_b_q;
    pipe_c_d    = pipe_c_q;
    pipe_d_d    = pipe_d_q;
    tag_issue_d = '0;  // bubble unless something is granted
    if (grant_vld) begin
      pipe_a_d    = req_a[int'(grant_idx)*DW +: DW];
      pipe_b_d    = req_b[int'(grant_idx)*DW +: DW];
      pipe_c_d    = req_c[int'(grant_idx)*DW +: DW];
      pipe_d_d    = req_d[int'(grant_idx)*DW +: DW];
      tag_issue_d = '{vld: 1'b1, id: grant_idx};
      ptr_d       = (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
    end

    tag_line_d[0] = tag_issue_q;
    for (int k = 1; k < PIPE_LAT; k++) begin
      tag_line_d[k] = tag_line_q[k-1];
    end

    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (out_tag.vld) begin
      rsp_data_d = pipe_f;
      for (int i = 0; i < N_REQ; i++) begin
        rsp_valid_d[i] = (out_tag.id == ID_W'(i));
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idle_q      <= 1'b1;
      ptr_q       <= '0;
      pipe_a_q    <= '0;
      pipe_b_q    <= '0;
      pipe_c_q    <= '0;
      pipe_d_q    <= '0;
      tag_issue_q <= '0;
      // NOTE: the tag line is cleared on reset (unlike a data buffer) because
      // a stale vld bit would emit a response for an op that was discarded.
      for (int k = 0; k < PIPE_LAT; k++) begin
        tag_line_q[k] <= '0;
      end
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      idle_q      <= idle_d;
      ptr_q       <= ptr_d;
      pipe_a_q    <= pipe_a_d;
      pipe_b_q    <= pipe_b_d;
      pipe_c_q    <= pipe_c_d;
      pipe_d_q    <= pipe_d_d;
      tag_issue_q <= tag_issue_d;
      for (int k = 0; k < PIPE_LAT; k++) begin
        tag_line_q[k] <= tag_line_d[k];
      end
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign pipe_a    = pipe_a_q;
  assign pipe_b    = pipe_b_q;
  assign pipe_c    = pipe_c_q;
  assign pipe_d    = pipe_d_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign idle      = idle_q;

`ifdef PIPE_SCHED_STATS_EN
  // --------------------------------------------------------------------------
  // Statistics: saturating grant count per requester and busy-cycle count.
  // --------------------------------------------------------------------------
  logic [STAT_W-1:0] grant_cnt_q [N_REQ];
  logic [STAT_W-1:0] grant_cnt_d [N_REQ];
  logic [STAT_W-1:0] busy_cnt_q, busy_cnt_d;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      grant_cnt_d[i] = grant[i] ? sat_inc(grant_cnt_q[i]) : grant_cnt_q[i];
    end
    busy_cnt_d = line_busy ? sat_inc(busy_cnt_q) : busy_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        grant_cnt_q[i] <= '0;
      end
      busy_cnt_q <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        grant_cnt_q[i] <= grant_cnt_d[i];
      end
      busy_cnt_q <= busy_cnt_d;
    end
  end

  always_comb begin
    stat_grant_cnt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      stat_grant_cnt[i*STAT_W +: STAT_W] = grant_cnt_q[i];
    end
  end

  assign stat_busy_cnt = busy_cnt_q;
`endif

endmodule : pipe_sched_arbiter

// File: tb/tb_pipe_sched_arbiter.sv
// ----------------------------------------------------------------------------
// tb_pipe_sched_arbiter
//   Self-checking bench for pipe_sched_arbiter driving a real basic_pipeline.
//   A transaction-level model (in-flight queue with due edges, RR search,
//   mode variable) predicts every output each cycle; directed scenarios add
//   hand-computed literal expectations; a randomized phase follows.
//   With PIPE_SCHED_STATS_EN defined the statistics ports are also modelled
//   and a saturation run is added.
// ----------------------------------------------------------------------------
module tb_pipe_sched_arbiter;

  localparam int N   = 4;
  localparam int DW  = 10;
  localparam int LAT = 3;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*DW-1:0]   req_a, req_b, req_c, req_d;
  logic [DW-1:0]     pipe_a, pipe_b, pipe_c, pipe_d, pipe_f;
  logic [N-1:0]      rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic              idle;
`ifdef PIPE_SCHED_STATS_EN
  logic [N*16-1:0]   stat_grant_cnt;
  logic [15:0]       stat_busy_cnt;
`endif

  always #5 clk = ~clk;

  pipe_sched_arbiter #(.N_REQ(N), .DW(DW), .PIPE_LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_c     (req_c),
    .req_d     (req_d),
    .pipe_a    (pipe_a),
    .pipe_b    (pipe_b),
    .pipe_c    (pipe_c),
    .pipe_d    (pipe_d),
    .pipe_f    (pipe_f),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .idle      (idle)
`ifdef PIPE_SCHED_STATS_EN
    ,
    .stat_grant_cnt (stat_grant_cnt),
    .stat_busy_cnt  (stat_busy_cnt)
`endif
  );

  basic_pipeline #(.W(DW)) u_pipe (
    .clk (clk),
    .rst (rst),
    .a   (pipe_a),
    .b   (pipe_b),
    .c   (pipe_c),
    .d   (pipe_d),
    .f   (pipe_f)
  );

  // --------------------------------------------------------------------------
  // Bookkeeping
  // --------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model
  // --------------------------------------------------------------------------
  typedef struct {
    int due;
    int id;
    int f;
  } op_t;

  typedef struct {
    int id;
    int data;
    int edge_no;
  } ev_t;

  op_t          inflight[$];
  ev_t          rsp_log[$];
  ev_t          grant_log[$];
  int           edge_n   = 0;
  bit           model_ok = 1'b0;
  int           m_mode;
  int           m_ptr;
  logic [N-1:0] m_rsp_valid;
  logic [DW-1:0] m_rsp_data;
  logic         m_idle;
  logic [DW-1:0] m_pa, m_pb, m_pc, m_pd;
  int           m_gcnt [N];
  int           m_busy;

  function automatic int calc_f(input int a, input int b, input int c, input int d);
    return ((a + b + c - d) * d) & ((1 << DW) - 1);
  endfunction

  // Requester that must be granted right now, or -1.
  function automatic int model_grant();
    if (m_mode != M_RUN || en !== 1'b1) return -1;
    for (int off = 0; off < N; off++) begin
      if (req_valid[(m_ptr + off) % N]) return (m_ptr + off) % N;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int  g;
    bit  busy;
    edge_n++;
    if (rst) begin
      inflight.delete();
      m_mode      = M_IDLE;
      m_ptr       = 0;
      m_rsp_valid = '0;
      m_rsp_data  = '0;
      m_idle      = 1'b1;
      m_pa = '0; m_pb = '0; m_pc = '0; m_pd = '0;
      for (int i = 0; i < N; i++) m_gcnt[i] = 0;
      m_busy   = 0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      g    = model_grant();
      busy = (inflight.size() > 0);
      m_rsp_valid = '0;
      if (busy && inflight[0].due == edge_n) begin
        m_rsp_valid[inflight[0].id] = 1'b1;
        m_rsp_data = DW'(inflight[0].f);
        void'(inflight.pop_front());
      end
      if (busy && m_busy < 65535) m_busy++;
      case (m_mode)
        M_IDLE:  if (en)    m_mode = M_RUN;
        M_RUN:   if (!en)   m_mode = M_DRAIN;
        default: if (!busy) m_mode = M_IDLE;
      endcase
      if (g >= 0) begin
        m_pa = req_a[g*DW +: DW];
        m_pb = req_b[g*DW +: DW];
        m_pc = req_c[g*DW +: DW];
        m_pd = req_d[g*DW +: DW];
        inflight.push_back('{due: edge_n + LAT + 1, id: g,
                             f: calc_f(int'(m_pa), int'(m_pb), int'(m_pc), int'(m_pd))});
        m_ptr = (g + 1) % N;
        if (m_gcnt[g] < 65535) m_gcnt[g]++;
      end
      m_idle = (m_mode == M_IDLE);
    end
  end

  // --------------------------------------------------------------------------
  // Compare process: every cycle, away from the active edge.
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    int g;
    logic [N-1:0] er;
    if (model_ok) begin
      g  = model_grant();
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      check("req_ready", 64'(req_ready), 64'(er));
      check("rsp_valid", 64'(rsp_valid), 64'(m_rsp_valid));
      check("rsp_data",  64'(rsp_data),  64'(m_rsp_data));
      check("idle",      64'(idle),      64'(m_idle));
      check("pipe_a",    64'(pipe_a),    64'(m_pa));
      check("pipe_b",    64'(pipe_b),    64'(m_pb));
      check("pipe_c",    64'(pipe_c),    64'(m_pc));
      check("pipe_d",    64'(pipe_d),    64'(m_pd));
`ifdef PIPE_SCHED_STATS_EN
      for (int i = 0; i < N; i++) begin
        check($sformatf("stat_grant_cnt[%0d]", i), 64'(stat_grant_cnt[i*16 +: 16]), 64'(m_gcnt[i]));
      end
      check("stat_busy_cnt", 64'(stat_busy_cnt), 64'(m_busy));
`endif
      // Logs of what the DUT actually did, for the literal expectations.
      for (int i = 0; i < N; i++) begin
        if (rsp_valid[i]) rsp_log.push_back('{id: i, data: int'(rsp_data), edge_no: edge_n});
        if (req_ready[i] && req_valid[i]) grant_log.push_back('{id: i, data: 0, edge_no: edge_n + 1});
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers: inputs change 2 time units after the rising edge.
  // --------------------------------------------------------------------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic set_op(input int i, input int a, input int b, input int c, input int d);
    req_a[i*DW +: DW] = DW'(a);
    req_b[i*DW +: DW] = DW'(b);
    req_c[i*DW +: DW] = DW'(c);
    req_d[i*DW +: DW] = DW'(d);
  endtask

  task automatic clear_logs();
    rsp_log.delete();
    grant_log.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  initial begin
    int idle_edge;
    bit seen_idle;
    int t1_d1[5];
    int t2_res[5];

    rst = 1'b1; en = 1'b0; req_valid = '0;
    req_a = '0; req_b = '0; req_c = '0; req_d = '0;
    cyc(2);
    rst = 1'b0;
    #1;
    check("rst_req_ready", 64'(req_ready), 0);
    check("rst_idle",      64'(idle),      1);
    check("rst_rsp_valid", 64'(rsp_valid), 0);
    check("rst_rsp_data",  64'(rsp_data),  0);

    // 1: single operation on requester 0.
    en = 1'b1;
    cyc(1);                                  // IDLE -> RUN
    clear_logs();
    set_op(0, 10, 12, 6, 3);
    req_valid = 4'b0001;
    cyc(1);
    req_valid = '0;
    cyc(6);
    check("t1_rsp_count", 64'(rsp_log.size()), 1);
    if (rsp_log.size() >= 1 && grant_log.size() >= 1) begin
      check("t1_rsp_id",      64'(rsp_log[0].id),   0);
      check("t1_rsp_data",    64'(rsp_log[0].data), 75);
      check("t1_rsp_latency", 64'(rsp_log[0].edge_no - grant_log[0].edge_no), 4);
    end

    // 2: all four valid, round-robin 0,1,2,3,0 from a freshly reset pointer.
    do_reset();
    cyc(1);                                  // IDLE -> RUN (en still high)
    clear_logs();
    set_op(0, 10, 10, 5, 3);
    set_op(1, 20, 11, 1, 4);
    set_op(2, 15, 10, 8, 2);
    set_op(3, 10, 20, 5, 3);
    req_valid = 4'b1111;
    cyc(5);
    req_valid = '0;
    cyc(8);
    t2_res = '{66, 112, 62, 96, 66};
    check("t2_grant_count", 64'(grant_log.size()), 5);
    check("t2_rsp_count",   64'(rsp_log.size()),   5);
    for (int k = 0; k < 5; k++) begin
      if (k < grant_log.size()) begin
        check($sformatf("t2_grant_id[%0d]", k), 64'(grant_log[k].id), 64'(k % N));
        check($sformatf("t2_grant_edge[%0d]", k),
              64'(grant_log[k].edge_no - grant_log[0].edge_no), 64'(k));
      end
      if (k < rsp_log.size()) begin
        check($sformatf("t2_rsp_id[%0d]", k),   64'(rsp_log[k].id),   64'(k % N));
        check($sformatf("t2_rsp_data[%0d]", k), 64'(rsp_log[k].data), 64'(t2_res[k]));
      end
    end

    // 3: en dropped with 3 ops in flight, briefly re-raised during drain.
    clear_logs();
    req_valid = 4'b1111;
    cyc(3);
    en = 1'b0;
    #1;
    check("t3_ready_on_en_low", 64'(req_ready), 0);
    cyc(1);
    en = 1'b1;                               // re-raised while draining
    #1;
    check("t3_ready_in_drain", 64'(req_ready), 0);
    check("t3_idle_in_drain",  64'(idle),      0);
    seen_idle = 1'b0;
    idle_edge = 0;
    for (int k = 0; k < 20 && !seen_idle; k++) begin
      cyc(1);
      if (idle) begin
        seen_idle = 1'b1;
        idle_edge = edge_n;
      end
    end
    req_valid = '0;
    check("t3_idle_reached", 64'(seen_idle), 1);
    check("t3_rsp_count",    64'(rsp_log.size()), 3);
    if (rsp_log.size() >= 1) begin
      check("t3_idle_after_last_rsp", 64'(idle_edge > rsp_log[rsp_log.size()-1].edge_no), 1);
    end
    cyc(2);

    // 4: reset one cycle after two handshakes; those ops never respond.
    clear_logs();
    req_valid = 4'b1111;
    cyc(2);
    req_valid = '0;
    do_reset();
    en = 1'b0;
    #1;
    check("t4_req_ready", 64'(req_ready), 0);
    check("t4_pipe_a",    64'(pipe_a),    0);
    check("t4_pipe_b",    64'(pipe_b),    0);
    check("t4_pipe_c",    64'(pipe_c),    0);
    check("t4_pipe_d",    64'(pipe_d),    0);
    check("t4_rsp_valid", 64'(rsp_valid), 0);
    check("t4_rsp_data",  64'(rsp_data),  0);
    check("t4_idle",      64'(idle),      1);
    cyc(8);
    check("t4_grants_before_rst", 64'(grant_log.size()), 2);
    check("t4_no_rsp",            64'(rsp_log.size()),   0);

    // 5: only requester 2 valid; back-to-back grants, zero and wrap results.
    en = 1'b1;
    cyc(1);
    clear_logs();
    set_op(2, 30, 1, 2, 4);
    req_valid = 4'b0100;
    cyc(5);
    set_op(2, 8, 15, 5, 0);
    cyc(1);
    set_op(2, 1000, 100, 0, 1);
    cyc(1);
    req_valid = '0;
    cyc(8);
    t1_d1 = '{116, 116, 116, 116, 116};
    check("t5_grant_count", 64'(grant_log.size()), 7);
    check("t5_rsp_count",   64'(rsp_log.size()),   7);
    for (int k = 0; k < 7; k++) begin
      if (k < grant_log.size()) begin
        check($sformatf("t5_grant_id[%0d]", k), 64'(grant_log[k].id), 2);
        check($sformatf("t5_grant_edge[%0d]", k),
              64'(grant_log[k].edge_no - grant_log[0].edge_no), 64'(k));
      end
      if (k < rsp_log.size()) begin
        check($sformatf("t5_rsp_id[%0d]", k), 64'(rsp_log[k].id), 2);
        if (k < 5) check($sformatf("t5_rsp_data[%0d]", k), 64'(rsp_log[k].data), 64'(t1_d1[k]));
      end
    end
    if (rsp_log.size() >= 7) begin
      check("t5_rsp_zero", 64'(rsp_log[5].data), 0);
      check("t5_rsp_wrap", 64'(rsp_log[6].data), 75);
    end

    // Randomized phase: random en, valids, operands, occasional reset.
    for (int k = 0; k < 800; k++) begin
      en        = ($urandom_range(0, 9) != 0);
      req_valid = N'($urandom_range(0, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        set_op(i, $urandom_range(0, 1023), $urandom_range(0, 1023),
                  $urandom_range(0, 1023), $urandom_range(0, 1023));
      end
      rst = ($urandom_range(0, 99) == 0);
      cyc(1);
    end
    rst = 1'b0;

`ifdef PIPE_SCHED_STATS_EN
    // 6: grant counter saturation on requester 1.
    do_reset();
    en = 1'b1;
    cyc(1);
    set_op(1, 7, 8, 9, 2);
    req_valid = 4'b0010;
    cyc(70000);
    req_valid = '0;
    #1;
    check("t6_grant_cnt1_sat", 64'(stat_grant_cnt[1*16 +: 16]), 65535);
    check("t6_grant_cnt0",     64'(stat_grant_cnt[0*16 +: 16]), 0);
    check("t6_busy_sat",       64'(stat_busy_cnt), 65535);
`endif

    // Final drain.
    en = 1'b0;
    req_valid = '0;
    cyc(10);
    check("final_idle", 64'(idle), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pipe_sched_arbiter
